// File: rtl/uart_rx_massiv_unpacker.sv
// Snapshots the upstream UART RX massiv buffer (full or idle), pulses its clear, then streams packs on valid/ready.
// Optional: define UART_RX_UNPACKER_FULL_CNT_EN to add the OUT_FULL_EVENTS saturating full-snapshot counter.
module uart_rx_massiv_unpacker #(
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int RX_MASSIV_DEEP           = 2,
    parameter int RX_MASSIV_DEEP_LOG_2     = $clog2(RX_MASSIV_DEEP),
    parameter int TIMEOUT_CYCLES           = 64,
    parameter int CLEAR_PULSE_CYCLES       = 4
) (
    input  logic                                                IN_CLOCK,
    input  logic                                                IN_RESET,
    input  logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0]  IN_RX_DATA_MASSIV,
    input  logic [RX_MASSIV_DEEP_LOG_2:0]                       IN_RX_NUM_OF_DATA_PACKS_READY,
    input  logic [RX_MASSIV_DEEP_LOG_2:0]                       IN_RX_ERROR,
    output logic                                                OUT_RX_CLEAR_BUFFER,
    output logic [NUM_OF_DATA_BITS_IN_PACK-1:0]                 OUT_DATA,
    output logic                                                OUT_VALID,
    input  logic                                                IN_READY,
    output logic                                                OUT_LAST,
    output logic                                                OUT_BURST_ERROR,
    output logic                                                OUT_BUSY
`ifdef UART_RX_UNPACKER_FULL_CNT_EN
    ,
    output logic [7:0]                                          OUT_FULL_EVENTS
`endif
);

    localparam int W       = NUM_OF_DATA_BITS_IN_PACK;
    localparam int CNT_W   = RX_MASSIV_DEEP_LOG_2 + 1;
    localparam int IDX_W   = (RX_MASSIV_DEEP_LOG_2 > 0) ? RX_MASSIV_DEEP_LOG_2 : 1;
    localparam int T_MAX   = (TIMEOUT_CYCLES > CLEAR_PULSE_CYCLES) ? TIMEOUT_CYCLES : CLEAR_PULSE_CYCLES;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0]   DEEP         = CNT_W'(RX_MASSIV_DEEP);
    localparam logic [CNT_W-1:0]   ONE          = CNT_W'(1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(CLEAR_PULSE_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SNAP  = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   prev_cnt;
    logic [TIMER_W-1:0] timer;
    logic [W-1:0]       snap [RX_MASSIV_DEEP];
    logic [CNT_W-1:0]   n_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               clear_q;
    logic               valid_q;
    logic               last_q;
    logic               burst_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        cnt      = (IN_RX_NUM_OF_DATA_PACKS_READY > DEEP) ? DEEP : IN_RX_NUM_OF_DATA_PACKS_READY;
        idx_next = idx + IDX_W'(1);
    end

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state    <= S_IDLE;
            prev_cnt <= '0;
            timer    <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            idx      <= '0;
            clear_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            burst_q  <= 1'b0;
            // NOTE: the snapshot is a handful of flops, not a RAM, so clearing it on reset costs nothing structural.
            for (int k = 0; k < RX_MASSIV_DEEP; k++) snap[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cnt != '0) begin
                        state    <= S_WAIT;
                        prev_cnt <= cnt;
                        timer    <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else if (cnt == DEEP) begin
                        state <= S_SNAP;
                    end else if (cnt != prev_cnt) begin
                        prev_cnt <= cnt;
                        timer    <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state <= S_SNAP;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                S_SNAP: begin
                    for (int k = 0; k < RX_MASSIV_DEEP; k++) snap[k] <= IN_RX_DATA_MASSIV[k*W +: W];
                    n_q     <= cnt;
                    err_q   <= (IN_RX_ERROR != '0);
                    idx     <= '0;
                    timer   <= '0;
                    clear_q <= 1'b1;
                    state   <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (clear_q) begin
                        if (timer == PULSE_LAST) clear_q <= 1'b0;
                        else                     timer   <= timer + TIMER_W'(1);
                    end else if (cnt == '0) begin
                        // An upstream count that vanished during SNAP leaves nothing to stream.
                        if (n_q == '0) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_SEND;
                            valid_q <= 1'b1;
                            last_q  <= (n_q == ONE);
                            burst_q <= err_q;
                        end
                    end
                end
                S_SEND: begin
                    if (valid_q && IN_READY) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            burst_q <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            idx    <= idx_next;
                            last_q <= (CNT_W'(idx_next) == n_q - ONE);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_UNPACKER_FULL_CNT_EN
    logic [7:0] full_events;

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET)                                                  full_events <= '0;
        else if (state == S_SNAP && cnt == DEEP && full_events != 8'hFF) full_events <= full_events + 8'd1;
    end

    assign OUT_FULL_EVENTS = full_events;
`endif

    assign OUT_RX_CLEAR_BUFFER = clear_q;
    assign OUT_VALID           = valid_q;
    assign OUT_LAST            = last_q;
    assign OUT_BURST_ERROR     = burst_q;
    assign OUT_DATA            = valid_q ? snap[idx] : '0;
    assign OUT_BUSY            = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_massiv_unpacker.sv
// Directed bench for uart_rx_massiv_unpacker (W=8, D=2, timeout 64, clear pulse 4).
// Define UART_RX_UNPACKER_FULL_CNT_EN for both files to also exercise OUT_FULL_EVENTS.
module tb_uart_rx_massiv_unpacker;

    localparam int TIMEOUT = 64;
    // Sample latency from count appearing to clear high: IDLE->WAIT, WAIT->SNAP, SNAP->CLEAR.
    localparam int FULL_LAT = 3;
    // A partial buffer spends TIMEOUT-1 more WAIT edges while the timer runs 0..TIMEOUT-1.
    localparam int PART_LAT = FULL_LAT + TIMEOUT - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_data;
    logic [1:0]  rx_count;
    logic [1:0]  rx_error;
    logic        ready;
    logic        rx_clear;
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic        burst_error;
    logic        busy;
`ifdef UART_RX_UNPACKER_FULL_CNT_EN
    logic [7:0]  full_events;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_massiv_unpacker #(
        .NUM_OF_DATA_BITS_IN_PACK(8),
        .RX_MASSIV_DEEP(2),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CLEAR_PULSE_CYCLES(4)
    ) dut (
        .IN_CLOCK                     (clk),
        .IN_RESET                     (rst),
        .IN_RX_DATA_MASSIV            (rx_data),
        .IN_RX_NUM_OF_DATA_PACKS_READY(rx_count),
        .IN_RX_ERROR                  (rx_error),
        .OUT_RX_CLEAR_BUFFER          (rx_clear),
        .OUT_DATA                     (data),
        .OUT_VALID                    (valid),
        .IN_READY                     (ready),
        .OUT_LAST                     (last),
        .OUT_BURST_ERROR              (burst_error),
        .OUT_BUSY                     (busy)
`ifdef UART_RX_UNPACKER_FULL_CNT_EN
        ,
        .OUT_FULL_EVENTS              (full_events)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the upstream buffer: zeroes its count and error as soon as it sees the clear request.
    task automatic run_clear(input int budget, output int wait_cycles, output int high_cycles, output bit timed_out);
        wait_cycles = 0;
        high_cycles = 0;
        timed_out   = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rx_clear) begin
                if (high_cycles == 0) begin
                    wait_cycles = i + 1;
                    rx_count    = 2'd0;
                    rx_error    = 2'd0;
                end
                high_cycles++;
            end else if (high_cycles != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles = i + 1;
            if (valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; rx_data = '0; rx_count = '0; rx_error = '0;
        tick();
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
        checks++; if (burst_error !== 1'b0) begin errors++; $display("FAIL reset_burst_error: got %b expected 0", burst_error); end
        checks++; if (rx_clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", rx_clear); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_empty_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_buffer();
        int wc, hc, vc;
        bit to;
        rx_data = 16'hA55A; rx_error = 2'd0; ready = 1'b1; rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_clear_seen: got timeout=%0b expected 0", to); end
        checks++; if (wc != FULL_LAT) begin errors++; $display("FAIL full_clear_latency: got %0d expected %0d", wc, FULL_LAT); end
        checks++; if (hc != 4) begin errors++; $display("FAIL full_clear_width: got %0d expected 4", hc); end
        wait_valid(20, vc, to);
        checks++; if (to !== 1'b0 || vc != 1) begin errors++; $display("FAIL full_valid_latency: got %0d (timeout=%0b) expected 1", vc, to); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
        checks++; if ({valid, last, burst_error, data} !== {3'b100, 8'h5A}) begin errors++; $display("FAIL full_pack0: got v/l/e/d=%b%b%b/%h expected 100/5a", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, last, burst_error, data} !== {3'b110, 8'hA5}) begin errors++; $display("FAIL full_pack1: got v/l/e/d=%b%b%b/%h expected 110/a5", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, last, burst_error, data} !== {3'b000, 8'h00}) begin errors++; $display("FAIL full_end: got v/l/e/d=%b%b%b/%h expected 000/00", valid, last, burst_error, data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_back_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout_partial();
        int wc, hc, vc;
        bit to;
        rx_data = 16'hEE3C; rx_error = 2'd0; ready = 1'b1; rx_count = 2'd1;
        run_clear(200, wc, hc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL part_clear_seen: got timeout=%0b expected 0", to); end
        checks++; if (wc != PART_LAT) begin errors++; $display("FAIL part_clear_latency: got %0d expected %0d", wc, PART_LAT); end
        checks++; if (hc != 4) begin errors++; $display("FAIL part_clear_width: got %0d expected 4", hc); end
        wait_valid(20, vc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL part_valid_seen: got timeout=%0b expected 0", to); end
        checks++; if ({valid, last, burst_error, data} !== {3'b110, 8'h3C}) begin errors++; $display("FAIL part_pack0: got v/l/e/d=%b%b%b/%h expected 110/3c", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, last, burst_error, data} !== {3'b000, 8'h00}) begin errors++; $display("FAIL part_end: got v/l/e/d=%b%b%b/%h expected 000/00", valid, last, burst_error, data); end
    endtask

    task automatic test_count_rises();
        int wc, hc, vc;
        bit to;
        bit early_clear;
        early_clear = 1'b0;
        rx_data = 16'h1234; rx_error = 2'd0; ready = 1'b1; rx_count = 2'd1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rx_clear) early_clear = 1'b1;
        end
        checks++; if (early_clear !== 1'b0) begin errors++; $display("FAIL rise_no_early_clear: got %b expected 0", early_clear); end
        rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        checks++; if (to !== 1'b0 || wc != 2) begin errors++; $display("FAIL rise_clear_latency: got %0d (timeout=%0b) expected 2", wc, to); end
        wait_valid(20, vc, to);
        checks++; if ({valid, last, burst_error, data} !== {3'b100, 8'h34}) begin errors++; $display("FAIL rise_pack0: got v/l/e/d=%b%b%b/%h expected 100/34", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, last, burst_error, data} !== {3'b110, 8'h12}) begin errors++; $display("FAIL rise_pack1: got v/l/e/d=%b%b%b/%h expected 110/12", valid, last, burst_error, data); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rise_end: got valid=%b expected 0", valid); end
    endtask

    task automatic test_backpressure();
        int wc, hc, vc;
        bit to;
        rx_data = 16'hBEEF; rx_error = 2'd0; ready = 1'b0; rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        wait_valid(20, vc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_valid_seen: got timeout=%0b expected 0", to); end
        checks++; if ({valid, last, data} !== {2'b10, 8'hEF}) begin errors++; $display("FAIL bp_first: got v/l/d=%b%b/%h expected 10/ef", valid, last, data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({valid, last, data} !== {2'b10, 8'hEF}) begin errors++; $display("FAIL bp_hold[%0d]: got v/l/d=%b%b/%h expected 10/ef", i, valid, last, data); end
        end
        ready = 1'b1;
        tick();
        checks++; if ({valid, last, data} !== {2'b11, 8'hBE}) begin errors++; $display("FAIL bp_pack1: got v/l/d=%b%b/%h expected 11/be", valid, last, data); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_end: got valid=%b expected 0", valid); end
    endtask

    task automatic test_burst_error();
        int wc, hc, vc;
        bit to;
        rx_data = 16'h6699; rx_error = 2'd1; ready = 1'b1; rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        wait_valid(20, vc, to);
        checks++; if ({valid, last, burst_error, data} !== {3'b101, 8'h99}) begin errors++; $display("FAIL err_pack0: got v/l/e/d=%b%b%b/%h expected 101/99", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, last, burst_error, data} !== {3'b111, 8'h66}) begin errors++; $display("FAIL err_pack1: got v/l/e/d=%b%b%b/%h expected 111/66", valid, last, burst_error, data); end
        tick();
        checks++; if ({valid, burst_error} !== 2'b00) begin errors++; $display("FAIL err_after: got v/e=%b%b expected 00", valid, burst_error); end
    endtask

    task automatic test_count_clamp();
        int wc, hc, vc;
        bit to;
        rx_data = 16'h2211; rx_error = 2'd0; ready = 1'b1; rx_count = 2'd3;
        run_clear(200, wc, hc, to);
        checks++; if (to !== 1'b0 || wc != FULL_LAT) begin errors++; $display("FAIL clamp_clear_latency: got %0d (timeout=%0b) expected %0d", wc, to, FULL_LAT); end
        wait_valid(20, vc, to);
        checks++; if ({valid, last, data} !== {2'b10, 8'h11}) begin errors++; $display("FAIL clamp_pack0: got v/l/d=%b%b/%h expected 10/11", valid, last, data); end
        tick();
        checks++; if ({valid, last, data} !== {2'b11, 8'h22}) begin errors++; $display("FAIL clamp_pack1: got v/l/d=%b%b/%h expected 11/22", valid, last, data); end
        tick();
    endtask

    task automatic test_reset_mid_send();
        int wc, hc, vc;
        bit to;
        bit stray;
        rx_data = 16'h7788; rx_error = 2'd0; ready = 1'b0; rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        wait_valid(20, vc, to);
        checks++; if ({valid, data} !== {1'b1, 8'h88}) begin errors++; $display("FAIL rst_pre_pack0: got v/d=%b/%h expected 1/88", valid, data); end
`ifdef UART_RX_UNPACKER_FULL_CNT_EN
        checks++; if (full_events !== 8'd6) begin errors++; $display("FAIL rst_pre_full_events: got %0d expected 6", full_events); end
`endif
        rst = 1'b1;
        tick();
        checks++; if ({valid, last, burst_error, rx_clear, busy, data} !== 13'd0) begin errors++; $display("FAIL rst_mid_outputs: got v/l/e/c/b/d=%b%b%b%b%b/%h expected all 0", valid, last, burst_error, rx_clear, busy, data); end
        rst = 1'b0; ready = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_no_stray_transfer: got %b expected 0", stray); end
        rx_data = 16'hCAFE; rx_count = 2'd2;
        run_clear(200, wc, hc, to);
        checks++; if (to !== 1'b0 || wc != FULL_LAT || hc != 4) begin errors++; $display("FAIL rst_redrain_clear: got wait=%0d high=%0d timeout=%0b expected %0d/4/0", wc, hc, to, FULL_LAT); end
        wait_valid(20, vc, to);
        checks++; if ({valid, last, data} !== {2'b10, 8'hFE}) begin errors++; $display("FAIL rst_redrain_pack0: got v/l/d=%b%b/%h expected 10/fe", valid, last, data); end
        tick();
        checks++; if ({valid, last, data} !== {2'b11, 8'hCA}) begin errors++; $display("FAIL rst_redrain_pack1: got v/l/d=%b%b/%h expected 11/ca", valid, last, data); end
        tick();
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_redrain_end: got v/b=%b%b expected 00", valid, busy); end
`ifdef UART_RX_UNPACKER_FULL_CNT_EN
        checks++; if (full_events !== 8'd1) begin errors++; $display("FAIL rst_full_events: got %0d expected 1", full_events); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_buffer();
        test_timeout_partial();
        test_count_rises();
        test_backpressure();
        test_burst_error();
        test_count_clamp();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
